program_counter_sap2: RTL and testbench

// - Parametrised program counter for the SAP-2-class datapath.
// - Generalises the 4-bit SAP-1 counter:
//   - configurable address width
//   - bus load (unconditional JMP; conditional jumps are decided by the controller)
//   - halt freeze
//   - wrap indication
//   - optional hardware return-address stack for CALL/RET
// - Drives the shared W-bit bus through tri-state output and feeds the MAR directly.

---
 rtl/program_counter_sap2_if.sv | 31 +++
 rtl/program_counter_sap2.sv | 118 +++++++++++
 tb/tb_program_counter_sap2.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/program_counter_sap2_if.sv
// Control/status bundle between the SAP-2 controller and the program counter.
// The shared tri-state bus output is not carried here; it stays a plain wire
// port on the counter so the high-Z driver resolves on a real net.
interface program_counter_sap2_if #(
  parameter int ADDR_W = 8
);
  logic              count;
  logic              load;
  logic              call;
  logic              ret;
  logic              halt;
  logic              enable_output;
  logic [ADDR_W-1:0] from_BUS;
  logic [ADDR_W-1:0] addr_out;
  logic              wrapped;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_err;

  // Controller side: issues actions, observes address and flags.
  modport master (
    output count, load, call, ret, halt, enable_output, from_BUS,
    input  addr_out, wrapped, stack_empty, stack_full, stack_err
  );

  // Counter side.
  modport slave (
    input  count, load, call, ret, halt, enable_output, from_BUS,
    output addr_out, wrapped, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/program_counter_sap2.sv
// SAP-2 program counter: count, jump, halt freeze, wrap pulse and an optional
// hardware return-address stack. All state moves on the falling clock edge.
// Optional feature macro: CALL_STACK_EN (builds the CALL/RET stack; when
// undefined, call acts as a plain load and ret is ignored).
module program_counter_sap2 #(
  parameter int                         ADDR_W      = 8,
  parameter int                         STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]          RESET_ADDR  = '0
) (
  input  logic                 clock_i,
  input  logic                 clear_i,
  program_counter_sap2_if.slave pc_if,
  output wire  [ADDR_W-1:0]    to_bus_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              wrapped_q, wrapped_d;

  assign cnt_inc = cnt_q + 1'b1;

`ifdef CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SPW-1:0]    sp_q, sp_d, sp_m1;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic              err_q, err_d;
  logic              push;
  logic              empty, full;

  assign sp_m1 = sp_q - 1'b1;
  assign empty = (sp_q == '0);
  assign full  = (sp_q == SPW'(STACK_DEPTH));
`else
  logic unused_ret;
  assign unused_ret = pc_if.ret;
`endif

  // Next-state: one action per edge, halt > ret > call > load > count.
  always_comb begin
    cnt_d     = cnt_q;
    wrapped_d = 1'b0;
`ifdef CALL_STACK_EN
    sp_d      = sp_q;
    err_d     = err_q;
    push      = 1'b0;
`endif
    if (pc_if.halt) begin
      cnt_d = cnt_q;
`ifdef CALL_STACK_EN
    end else if (pc_if.ret) begin
      // Popping an empty stack leaves the counter alone and flags the fault.
      if (empty) begin
        err_d = 1'b1;
      end else begin
        cnt_d = stk_q[sp_m1[SIW-1:0]];
        sp_d  = sp_m1;
      end
    end else if (pc_if.call) begin
      // A call into a full stack neither pushes nor jumps.
      if (full) begin
        err_d = 1'b1;
      end else begin
        push  = 1'b1;
        sp_d  = sp_q + 1'b1;
        cnt_d = pc_if.from_BUS;
      end
`else
    end else if (pc_if.call) begin
      cnt_d = pc_if.from_BUS;
`endif
    end else if (pc_if.load) begin
      cnt_d = pc_if.from_BUS;
    end else if (pc_if.count) begin
      cnt_d     = cnt_inc;
      wrapped_d = &cnt_q;
    end
  end

  // Counter, wrap pulse and stack bookkeeping with synchronous clear.
  always_ff @(negedge clock_i) begin
    if (!clear_i) begin
      cnt_q     <= RESET_ADDR;
      wrapped_q <= 1'b0;
`ifdef CALL_STACK_EN
      sp_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
`ifdef CALL_STACK_EN
      sp_q      <= sp_d;
      err_q     <= err_d;
`endif
    end
  end

`ifdef CALL_STACK_EN
  // Stack storage: no reset, entries above sp are don't-care.
  always_ff @(negedge clock_i) begin
    if (clear_i && push) stk_q[sp_q[SIW-1:0]] <= cnt_inc;
  end

  assign pc_if.stack_empty = empty;
  assign pc_if.stack_full  = full;
  assign pc_if.stack_err   = err_q;
`else
  assign pc_if.stack_empty = 1'b1;
  assign pc_if.stack_full  = 1'b0;
  assign pc_if.stack_err   = 1'b0;
`endif

  assign pc_if.addr_out = cnt_q;
  assign pc_if.wrapped  = wrapped_q;
  assign to_bus_o       = pc_if.enable_output ? cnt_q : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_program_counter_sap2.sv
// Bench for program_counter_sap2 (ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0):
// directed scenarios followed by random actions, all checked against a
// queue-based reference model of the counter and return stack.
module tb_program_counter_sap2;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
`ifdef CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clock;
  logic          clear;
  wire  [AW-1:0] to_bus;

  program_counter_sap2_if #(.ADDR_W(AW)) pif ();

  program_counter_sap2 #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
    .clock_i  (clock),
    .clear_i  (clear),
    .pc_if    (pif),
    .to_bus_o (to_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk [$];
  logic          m_err;
  logic          m_wrap;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one action from the architectural rules.
  task automatic model(input bit cl, input bit h, input bit r, input bit c,
                       input bit l, input bit n, input logic [AW-1:0] b);
    if (!cl) begin
      m_pc = 8'h00; m_stk.delete(); m_err = 1'b0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (h) begin
        // frozen
      end else if (STK && r) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_pc = m_stk.pop_back();
      end else if (c) begin
        if (!STK) m_pc = b;
        else if (m_stk.size() == DEPTH) m_err = 1'b1;
        else begin
          m_stk.push_back(AW'((int'(m_pc) + 1) % 256));
          m_pc = b;
        end
      end else if (l) begin
        m_pc = b;
      end else if (n) begin
        m_wrap = (m_pc == 8'hFF);
        m_pc   = AW'((int'(m_pc) + 1) % 256);
      end
    end
  endtask

  // Drive one cycle of inputs, let the falling edge apply it, then check.
  task automatic step(input string tag, input bit cl, input bit h, input bit r,
                      input bit c, input bit l, input bit n, input bit oe,
                      input logic [AW-1:0] b);
    clear = cl; pif.halt = h; pif.ret = r; pif.call = c; pif.load = l;
    pif.count = n; pif.enable_output = oe; pif.from_BUS = b;
    @(negedge clock);
    model(cl, h, r, c, l, n, b);
    #1;
    chk({tag, ".addr"},  pif.addr_out, m_pc);
    chk({tag, ".wrap"},  AW'(pif.wrapped), AW'(m_wrap));
    chk({tag, ".empty"}, AW'(pif.stack_empty), AW'(m_stk.size() == 0));
    chk({tag, ".full"},  AW'(pif.stack_full), AW'(m_stk.size() == DEPTH));
    chk({tag, ".err"},   AW'(pif.stack_err), AW'(m_err));
    if (oe) chk({tag, ".bus"}, to_bus, m_pc);
  endtask

  initial begin
    m_pc = '0; m_err = 1'b0; m_wrap = 1'b0;
    clear = 1'b0; pif.halt = 0; pif.ret = 0; pif.call = 0; pif.load = 0;
    pif.count = 0; pif.enable_output = 0; pif.from_BUS = '0;

    // Clear dominates count and load.
    step("rst0", 0, 0, 0, 0, 1, 1, 0, 8'h33);
    step("rst1", 0, 0, 0, 0, 1, 1, 0, 8'h33);

    // Roll over all-ones.
    step("ldFE", 1, 0, 0, 0, 1, 0, 1, 8'hFE);
    step("cnt1", 1, 0, 0, 0, 0, 1, 1, 8'h00);
    step("cnt2", 1, 0, 0, 0, 0, 1, 1, 8'h00);
    step("cnt3", 1, 0, 0, 0, 0, 1, 1, 8'h00);

    // Halt outranks load/count; load outranks count.
    step("halt", 1, 1, 0, 0, 1, 1, 1, 8'h40);
    step("ld40", 1, 0, 0, 0, 1, 1, 1, 8'h40);
    step("idle", 1, 0, 0, 0, 0, 0, 1, 8'h77);

`ifdef CALL_STACK_EN
    step("ld10", 1, 0, 0, 0, 1, 0, 1, 8'h10);
    step("c80",  1, 0, 0, 1, 0, 0, 1, 8'h80);
    step("c90",  1, 0, 0, 1, 0, 0, 1, 8'h90);
    step("r1",   1, 0, 1, 0, 0, 0, 1, 8'h00);
    step("r2",   1, 0, 1, 0, 0, 0, 1, 8'h00);
    step("r3",   1, 0, 1, 0, 0, 0, 1, 8'h00);
    step("clr",  0, 0, 0, 0, 0, 0, 1, 8'h00);
    step("cr",   1, 0, 1, 1, 0, 0, 1, 8'h22);  // ret wins over call on empty stack
    step("clr2", 0, 0, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) step("cN", 1, 0, 0, 1, 0, 0, 1, AW'(8'h20 + i));
    step("cAA",  1, 0, 0, 1, 0, 0, 1, 8'hAA);
    step("clrM", 0, 0, 0, 1, 0, 1, 1, 8'hAA);
`else
    step("c55",  1, 0, 0, 1, 0, 0, 1, 8'h55);
    step("ret",  1, 0, 1, 0, 0, 0, 1, 8'h00);
    step("retN", 1, 0, 1, 0, 0, 0, 1, 8'h00);
`endif

    // Random actions; bias toward the top of the range to exercise wrap.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] b;
      b = (($urandom_range(0, 3) == 0) ? 8'hFC : 8'h00) | AW'($urandom_range(0, 255));
      step("rnd", $urandom_range(0, 40) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
